hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage core. It consumes the Execute-stage control outputs of the ID/EX register, together with register addresses from Decode, Execute, Memory and Writeback, and drives the stall, flush and forwarding controls back into the fetch, decode, ID/EX and EX/MEM registers. It resolves three hazards: load-use stalls, taken-branch flushes and, optionally, multi-cycle multiply stalls. It also keeps a saturating count of stall cycles for debug.

## Interface
- `MUL_LATENCY`, default 4: total Execute cycles a multiply occupies; legal range 2..15.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `RA1D`, `RA2D`  in  4 each  source register addresses in Decode.
- `RA1E`, `RA2E`  in  4 each  source register addresses in Execute.
- `WA3E`, `WA3M`, `WA3W`  in  4 each  destination register addresses in Execute, Memory and Writeback.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  register-write enables per stage.
- `MemtoRegE`  in  1  the instruction in Execute is a load.
- `PCSrcE`  in  1  a taken branch is resolving in Execute.
- `MulStartE`  in  1  a multiply has entered Execute this cycle.
- `StallF`, `StallD`, `StallE`  out  1 each  hold the PC, IF/ID and ID/EX registers.
- `FlushD`, `FlushE`, `FlushM`  out  1 each  insert a bubble into IF/ID, ID/EX and EX/MEM.
- `ForwardAE`, `ForwardBE`  out  2 each  ALU operand source: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- `StallCnt`  out  `CNT_W`  saturating count of cycles with `StallF` high.

## Operation
- Forwarding is combinational:
  - `ForwardAE` = 10 if `RegWriteM` and `WA3M == RA1E`.
  - Otherwise 01 if `RegWriteW` and `WA3W == RA1E`.
  - Otherwise 00.
  - `ForwardBE` follows the same rules using `RA2E`.
  - Memory has priority over Writeback.
- Load-use condition `LdStall` = `MemtoRegE & RegWriteE & (WA3E == RA1D | WA3E == RA2D)`.
- The FSM has two states, RUN and MULBUSY, plus a down-counter `mcnt` of width `$clog2(MUL_LATENCY)`.
- In RUN, outputs are evaluated in this priority order:
  1. `PCSrcE`: `FlushD` = `FlushE` = 1, all stalls 0. A load-use hazard in the same cycle is discarded, because the dependent instruction is flushed.
  2. `MulStartE`: `StallF` = `StallD` = `StallE` = 1 and `FlushM` = 1. Next state is MULBUSY with `mcnt` = `MUL_LATENCY` − 2.
  3. `LdStall`: `StallF` = `StallD` = 1 and `FlushE` = 1, for exactly one cycle. No state change.
  4. Otherwise all stall and flush outputs are 0.
- In MULBUSY:
  - `StallF` = `StallD` = `StallE` = `FlushM` = 1.
  - `PCSrcE`, `MulStartE` and `LdStall` are ignored.
  - When `mcnt` == 0, next state is RUN; otherwise `mcnt` decrements.
- `StallCnt` increments on every cycle with `StallF` = 1 and saturates at all-ones; it does not wrap.

## Timing
- A multiply holds Execute for `MUL_LATENCY` cycles in total: the `MulStartE` cycle plus `MUL_LATENCY` − 1 further stall cycles. The first cycle after leaving MULBUSY is unstalled.
- A load-use stall costs exactly 1 cycle. On the next cycle the load is in Memory, and `ForwardAE`/`ForwardBE` select 01 from Writeback one cycle after that.
- A branch flush costs 2 bubbles (Decode and Execute) in a single cycle.
- Reset: state RUN, `mcnt` = 0, `StallCnt` = 0. While `reset` is high, all stall and flush outputs are 0. Forward outputs remain purely combinational.
- Reset asserted in MULBUSY returns to RUN on the next edge. No stall is asserted in the cycle after reset deasserts unless it is caused by that cycle's own inputs.

## Configuration
- `HAZARD_MUL_STALL_EN` defined: MULBUSY, `mcnt` and `MulStartE` handling are compiled in as described above.
- `HAZARD_MUL_STALL_EN` undefined:
  - `MulStartE` is ignored and the FSM is permanently RUN.
  - `StallE` and `FlushM` are tied to 0.
  - `MUL_LATENCY` is unused.

## Structure
- The shared package `hazard_pkg` holds:
  - the state enum `hz_state_t` (RUN, MULBUSY);
  - the forward-select constants `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10;
  - the register address width `REG_AW` = 4.
- The forwarding mux select logic, instanced twice, is the natural single sub-module `fwd_sel`, with inputs `RA`, `WA3M`, `WA3W`, `RegWriteM`, `RegWriteW` and output `Fwd`.

## Test plan
- `RegWriteM`=1, `WA3M`=3, `RA1E`=3; `RegWriteW`=1, `WA3W`=3 → `ForwardAE`=10. With `RegWriteM`=0 → `ForwardAE`=01. With `RA2E`=5 → `ForwardBE`=00.
- Load with `WA3E`=7, `MemtoRegE`=1, `RegWriteE`=1, `RA2D`=7 → one cycle with `StallF`=`StallD`=`FlushE`=1; next cycle all 0; `StallCnt` goes 0→1.
- Same load-use condition with `PCSrcE`=1 → `FlushD`=`FlushE`=1, `StallF`=0, `StallCnt` unchanged.
- `MUL_LATENCY`=4, `MulStartE` pulse → `StallE` high for exactly 4 consecutive cycles. `PCSrcE` pulsed during cycle 2 has no effect. `StallCnt` = 4.
- `reset` asserted during MULBUSY cycle 2 → next cycle all stalls 0, `StallCnt`=0. A 70000-cycle stall run with `CNT_W`=16 → `StallCnt` saturates at 65535.
- Build without `HAZARD_MUL_STALL_EN`, pulse `MulStartE` → `StallE`=`FlushM`=0 on every cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state type, forward-select codes and register address width.
package hazard_pkg;

    localparam int REG_AW = 4;

    typedef logic [REG_AW-1:0] regAddr_t;

    typedef enum logic {
        RUN     = 1'b0,
        MULBUSY = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // True when a later stage will write the register an Execute operand reads.
    function automatic logic addrHit(input logic writeEn, input regAddr_t wa, input regAddr_t ra);
        return writeEn && (wa == ra);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle for the hazard controller: register addresses, stage
// controls in, stall/flush/forward controls and the debug stall count out.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    regAddr_t RA1D, RA2D;
    regAddr_t RA1E, RA2E;
    regAddr_t WA3E, WA3M, WA3W;
    logic     RegWriteE, RegWriteM, RegWriteW;
    logic     MemtoRegE;
    logic     PCSrcE;
    logic     MulStartE;

    logic       StallF, StallD, StallE;
    logic       FlushD, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, MulStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, StallCnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, MulStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, StallCnt
    );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one Execute operand; Memory result wins over Writeback.
module fwd_sel
    import hazard_pkg::*;
(
    input  regAddr_t   RA,
    input  regAddr_t   WA3M,
    input  regAddr_t   WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] Fwd
);

    always_comb begin
        Fwd = FWD_RF;
        if (addrHit(RegWriteM, WA3M, RA)) begin
            Fwd = FWD_MEM;
        end else if (addrHit(RegWriteW, WA3W, RA)) begin
            Fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: load-use stalls, taken-branch flushes, forwarding and a
// saturating stall counter. Multi-cycle multiply stalls need HAZARD_MUL_STALL_EN.
//
// state   | meaning
// RUN     | normal issue; branch, multiply start and load-use resolved by priority
// MULBUSY | multiply occupying Execute; front end and ID/EX held, EX/MEM bubbled
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    if (MUL_LATENCY < 2 || MUL_LATENCY > 15) begin : gLatCheck
        $error("hazard_unit: MUL_LATENCY must be in 2..15");
    end

    logic       ldStall;
    logic       stallF, stallD, stallE;
    logic       flushD, flushE, flushM;
    logic [1:0] fwdA, fwdB;
    logic [CNT_W-1:0] stallCnt;

    fwd_sel uFwdA (
        .RA        (hz.RA1E),
        .WA3M      (hz.WA3M),
        .WA3W      (hz.WA3W),
        .RegWriteM (hz.RegWriteM),
        .RegWriteW (hz.RegWriteW),
        .Fwd       (fwdA)
    );

    fwd_sel uFwdB (
        .RA        (hz.RA2E),
        .WA3M      (hz.WA3M),
        .WA3W      (hz.WA3W),
        .RegWriteM (hz.RegWriteM),
        .RegWriteW (hz.RegWriteW),
        .Fwd       (fwdB)
    );

    assign ldStall = hz.MemtoRegE && hz.RegWriteE &&
                     ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

`ifdef HAZARD_MUL_STALL_EN
    localparam int MCNT_W = $clog2(MUL_LATENCY);
    localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MUL_LATENCY - 2);

    hz_state_t         state, stateNext;
    logic [MCNT_W-1:0] mcnt, mcntNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            mcnt  <= '0;
        end else begin
            state <= stateNext;
            mcnt  <= mcntNext;
        end
    end
`endif

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
`ifdef HAZARD_MUL_STALL_EN
        stateNext = state;
        mcntNext  = mcnt;
`endif
        // Reset forces every stall/flush low so the pipeline restarts cleanly.
        if (!reset) begin
`ifdef HAZARD_MUL_STALL_EN
            if (state == MULBUSY) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
                if (mcnt == '0) begin
                    stateNext = RUN;
                end else begin
                    mcntNext = mcnt - 1'b1;
                end
            end else
`endif
            if (hz.PCSrcE) begin
                // A load-use hazard here is moot: the dependent instruction is flushed.
                flushD = 1'b1;
                flushE = 1'b1;
            end
`ifdef HAZARD_MUL_STALL_EN
            else if (hz.MulStartE) begin
                stallF    = 1'b1;
                stallD    = 1'b1;
                stallE    = 1'b1;
                flushM    = 1'b1;
                stateNext = MULBUSY;
                mcntNext  = MCNT_INIT;
            end
`endif
            else if (ldStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (stallF && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign hz.StallF    = stallF;
    assign hz.StallD    = stallD;
    assign hz.StallE    = stallE;
    assign hz.FlushD    = flushD;
    assign hz.FlushE    = flushE;
    assign hz.FlushM    = flushM;
    assign hz.ForwardAE = fwdA;
    assign hz.ForwardBE = fwdB;
    assign hz.StallCnt  = stallCnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: cycle-level behavioural model plus
// directed vectors with literal expectations. Honors HAZARD_MUL_STALL_EN.
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_MUL_STALL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_unit #(.MUL_LATENCY(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int nCmp = 0;
    int nErr = 0;
    bit checkEn = 1'b0;

    // Model state: remaining multiply stall cycles after the current one, stall count.
    int mulLeft = 0;
    int expCnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] expFwd(input regAddr_t ra);
        if (hz.RegWriteM && hz.WA3M == ra) return 2'b10;
        if (hz.RegWriteW && hz.WA3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    function automatic logic [5:0] expCtrl();
        bit loadUse;
        loadUse = hz.MemtoRegE && hz.RegWriteE &&
                  (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
        if (reset)                    return 6'b000_000;
        if (mulLeft > 0)              return 6'b111_001;
        if (hz.PCSrcE)                return 6'b000_110;
        if (MUL_EN && hz.MulStartE)   return 6'b111_001;
        if (loadUse)                  return 6'b110_010;
        return 6'b000_000;
    endfunction

    always @(posedge clk) begin
        logic [5:0] c;
        c = expCtrl();
        if (reset) begin
            mulLeft = 0;
            expCnt  = 0;
        end else begin
            if (c[5] && expCnt < CNT_MAX) expCnt++;
            if (mulLeft > 0) mulLeft--;
            else if (!hz.PCSrcE && MUL_EN && hz.MulStartE) mulLeft = MUL_LAT - 1;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("ctrl", {26'd0, hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM},
                  {26'd0, expCtrl()});
            check("ForwardAE", {30'd0, hz.ForwardAE}, {30'd0, expFwd(hz.RA1E)});
            check("ForwardBE", {30'd0, hz.ForwardBE}, {30'd0, expFwd(hz.RA2E)});
            check("StallCnt", {16'd0, hz.StallCnt}, expCnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        hz.RA1D = '0; hz.RA2D = '0; hz.RA1E = '0; hz.RA2E = '0;
        hz.WA3E = 4'hF; hz.WA3M = 4'hF; hz.WA3W = 4'hF;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemtoRegE = 0; hz.PCSrcE = 0; hz.MulStartE = 0;
        hz.RA1D = 4'h1; hz.RA2D = 4'h2; hz.RA1E = 4'h1; hz.RA2E = 4'h2;
    endtask

    task automatic setLoadUse();
        hz.WA3E = 4'd7; hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.RA2D = 4'd7;
    endtask

    initial begin
        int nStallE;
        int nMulOut;
        reset = 1'b1;
        clearIn();
        cyc();
        checkEn = 1'b1;
        cyc();
        @(negedge clk);
        check("reset StallCnt", {16'd0, hz.StallCnt}, 0);
        check("reset StallF", {31'd0, hz.StallF}, 0);

        cyc();
        reset = 1'b0;
        hz.RegWriteM = 1; hz.WA3M = 4'd3; hz.RA1E = 4'd3;
        hz.RegWriteW = 1; hz.WA3W = 4'd3; hz.RA2E = 4'd5;
        @(negedge clk);
        check("fwd mem prio", {30'd0, hz.ForwardAE}, 2);
        check("fwd B none", {30'd0, hz.ForwardBE}, 0);
        cyc();
        hz.RegWriteM = 0;
        @(negedge clk);
        check("fwd wb", {30'd0, hz.ForwardAE}, 1);
        cyc();
        hz.RegWriteM = 1; hz.WA3M = 4'd5; hz.WA3W = 4'd5; hz.RA1E = 4'd9;
        @(negedge clk);
        check("fwd B mem", {30'd0, hz.ForwardBE}, 2);
        check("fwd A none", {30'd0, hz.ForwardAE}, 0);

        // Load-use on operand B: one stall cycle, then clear.
        cyc();
        clearIn();
        setLoadUse();
        @(negedge clk);
        check("ld StallF", {31'd0, hz.StallF}, 1);
        check("ld FlushE", {31'd0, hz.FlushE}, 1);
        cyc();
        clearIn();
        @(negedge clk);
        check("ld after StallF", {31'd0, hz.StallF}, 0);
        check("ld StallCnt", {16'd0, hz.StallCnt}, 1);

        // Loads not writing a register, and load-use via operand A.
        cyc();
        setLoadUse();
        hz.RegWriteE = 0;
        cyc();
        clearIn();
        hz.WA3E = 4'd4; hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.RA1D = 4'd4;
        cyc();
        clearIn();

        // Branch beats load-use.
        cyc();
        setLoadUse();
        hz.PCSrcE = 1;
        @(negedge clk);
        check("br FlushD", {31'd0, hz.FlushD}, 1);
        check("br StallF", {31'd0, hz.StallF}, 0);
        cyc();
        clearIn();
        @(negedge clk);
        check("br StallCnt", {16'd0, hz.StallCnt}, 2);

        // Multiply pulse with a branch in its second cycle.
        nStallE = 0;
        nMulOut = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            hz.MulStartE = (i == 0);
            hz.PCSrcE    = (i == 1);
            @(negedge clk);
            if (hz.StallE) nStallE++;
            if (hz.StallE || hz.FlushM) nMulOut++;
        end
        cyc();
        clearIn();
        @(negedge clk);
        check("mul StallE cycles", nStallE, MUL_EN ? MUL_LAT : 0);
        check("mul out cycles", nMulOut, MUL_EN ? MUL_LAT : 0);
        check("mul StallCnt", {16'd0, hz.StallCnt}, MUL_EN ? 2 + MUL_LAT : 2);

        // Reset during the multiply's second cycle.
        cyc();
        hz.MulStartE = 1;
        cyc();
        hz.MulStartE = 0;
        reset = 1'b1;
        @(negedge clk);
        check("rst mid StallF", {31'd0, hz.StallF}, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst post StallF", {31'd0, hz.StallF}, 0);
        check("rst post StallE", {31'd0, hz.StallE}, 0);
        check("rst post StallCnt", {16'd0, hz.StallCnt}, 0);

        // Long stall run to saturate the counter.
        cyc();
        setLoadUse();
        repeat (70000) cyc();
        @(negedge clk);
        check("sat StallCnt", {16'd0, hz.StallCnt}, 65535);
        cyc();
        clearIn();
        cyc();
        @(negedge clk);
        check("sat hold", {16'd0, hz.StallCnt}, 65535);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
